iob_sseg_scan: RTL and testbench
================================

# iob_sseg_scan

Four-digit seven-segment scan controller that sits directly downstream of the GPIO peripheral. It consumes the digit, decimal-point and enable values that software writes into the GPIO output registers, and time-multiplexes them onto the board's common-anode display (AN[3:0], segment cathodes, DP). It adds a per-digit guard interval to suppress ghosting, decodes hex digits to segment patterns, and pulses a frame marker once per full scan.

## Interface
Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range 2..2^DIV_W-1.
- GUARD, 4: cycles at the start of each slot with all anodes off. Legal range 1..REFRESH_DIV-1.
- DIV_W, 17: width of the slot counter.

Ports (all outputs registered):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 forces the reset state immediately.
- en  in  1  scan enable.
- digits  in  16  four hex nibbles; digit i = digits[4i+3:4i]; digit 0 is rightmost.
- dp  in  4  decimal point request per digit, active-high.
- digit_en  in  4  per-digit display mask, active-high.
- AN  out  4  anode drives, active-low; AN[i] selects digit i.
- SEG  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse at the end of each complete 4-digit scan.

## Operation
- State: IDLE, GUARD, ON. Digit index idx (2 bits). Slot counter cnt (DIV_W bits).
- Reset values: state IDLE, idx 0, cnt 0, AN 4'hF, SEG 7'h7F, DP 1, frame_done 0.
- IDLE: outputs blanked (AN 4'hF, SEG 7'h7F, DP 1). When en is sampled at 1, the next state is GUARD with idx 0 and cnt 0.
- In GUARD and ON, cnt increments by 1 every cycle.
  - GUARD covers cnt 0..GUARD-1. Outputs are blanked during GUARD.
  - When cnt reaches GUARD, the block enters ON. On that same edge it latches the active digit: nibble N = digits[4*idx+3:4*idx], plus dp[idx] and digit_en[idx].
  - Input changes after the latch edge have no effect until the next slot.
- ON drives SEG = decode(N) and DP = ~dp[idx].
  - AN has only bit idx low, but only if digit_en[idx]=1. Otherwise AN stays 4'hF. The slot still takes its full time so brightness stays uniform.
- Slot end: when cnt = REFRESH_DIV-1, the next edge sets cnt to 0, sets idx to idx+1 (wrapping 3 -> 0) and returns to GUARD.
- frame_done is 1 for exactly the one cycle that follows the edge on which idx wraps from 3 to 0.
- Decode table (hex value -> SEG): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E.
- en sampled at 0 in any state: the next state is IDLE, idx and cnt return to 0, outputs are blanked on that edge, and frame_done is 0.
- Asynchronous reset takes priority over everything, including a reset asserted mid-slot.

## Timing
- Let E0 be the edge that samples en=1 from IDLE. Digit k (k = 0..3) has AN[k] low from edge E0 + k·REFRESH_DIV + GUARD up to edge E0 + (k+1)·REFRESH_DIV.
  - That is REFRESH_DIV-GUARD cycles lit per slot.
  - AN = 4'hF for the GUARD cycles between slots.
- frame_done is high from edge E0 + 4·REFRESH_DIV for one cycle, then every 4·REFRESH_DIV cycles after that.
- Latency from an input change to a visible change is at most 4·REFRESH_DIV cycles.
- Any two bits of AN are never low in the same cycle.
- After en falls, the outputs are blank one edge later.

## Test plan
Bench parameters: REFRESH_DIV=8, GUARD=2.
- Reset: rst=0 with en=1 -> AN=F, SEG=7F, DP=1, frame_done=0, held for the whole time rst=0. Releasing rst with en=1 -> AN[0]=0 appears exactly 3 edges after release (1 edge to leave IDLE, then GUARD=2).
- Decode and scan: digits=16'h12AF, dp=4'b0100, digit_en=F, en=1.
  - AN sequence (each entry 6 cycles, separated by 2-cycle F gaps): E, D, B, 7.
  - SEG per slot: 0E, 08, 24, 79.
  - DP=0 only while AN=B.
  - frame_done pulses once every 32 cycles.
- Mid-slot input change: change digits to 16'h0000 in the 3rd ON cycle of digit 0 -> SEG holds 0E until that slot ends. The next slot shows 40 (digit 1 = 0).
- Mask: digit_en=4'b1010 -> AN is F throughout the slots of digits 0 and 2. Slot lengths and frame_done period are unchanged (32 cycles).
- en drop: set en=0 in the middle of digit 2's ON phase -> next edge gives AN=F, SEG=7F, frame_done=0. Re-asserting en restarts at digit 0 after the GUARD gap.
- Async reset mid-frame: pulse rst low for less than one cycle during digit 3 -> outputs blank immediately, with no frame_done pulse. The scan restarts at digit 0.

Source files
------------

// File: rtl/iob_sseg_scan.sv
// ---------------------------------------------------------------------------
// iob_sseg_scan
// Four-digit seven-segment scan controller for a common-anode display.
// Each digit gets one slot of REFRESH_DIV cycles. The first GUARD cycles of
// every slot keep all anodes off to suppress ghosting. The remaining cycles
// light the digit that was captured when the guard interval ended.
// A one-cycle frame marker follows the end of every complete 4-digit scan.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         scan enable; 0 blanks the display and restarts the scan
//   digits     four hex nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp         per-digit decimal point request, active-high
//   digit_en   per-digit display mask, active-high
//   AN         anode drives, active-low, AN[i] selects digit i
//   SEG        cathodes {g,f,e,d,c,b,a}, active-low
//   DP         decimal-point cathode, active-low
//   frame_done one-cycle pulse after the digit index wraps 3 -> 0
// ---------------------------------------------------------------------------
module iob_sseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int DIV_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] L_GUARD_LAST = DIV_W'(GUARD - 1);
    localparam logic [DIV_W-1:0] L_SLOT_LAST  = DIV_W'(REFRESH_DIV - 1);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [DIV_W-1:0] r_cnt;
    logic [3:0]       r_nib;      // digit value captured for the current slot
    logic             r_dp_req;
    logic             r_dig_en;

    state_t           w_state_nxt;
    logic [1:0]       w_idx_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [3:0]       w_nib_nxt;
    logic             w_dp_req_nxt;
    logic             w_dig_en_nxt;
    logic             w_wrap;

    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;
    logic             w_fd_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // State register. Outputs are registered too, so they are loaded from
    // the values the output logic computes for the next state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_cnt      <= '0;
            r_nib      <= 4'h0;
            r_dp_req   <= 1'b0;
            r_dig_en   <= 1'b0;
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_nib      <= w_nib_nxt;
            r_dp_req   <= w_dp_req_nxt;
            r_dig_en   <= w_dig_en_nxt;
            AN         <= w_an_nxt;
            SEG        <= w_seg_nxt;
            DP         <= w_dp_nxt;
            frame_done <= w_fd_nxt;
        end
    end

    // Next-state logic. A low en overrides everything and restarts the scan.
    // NOTE: every signal gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_nib_nxt    = r_nib;
        w_dp_req_nxt = r_dp_req;
        w_dig_en_nxt = r_dig_en;
        w_wrap       = 1'b0;

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_GUARD;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
                S_GUARD: begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                    // Guard ends: capture the digit so later input changes
                    // cannot disturb the slot that is now being shown.
                    if (r_cnt == L_GUARD_LAST) begin
                        w_state_nxt  = S_ON;
                        w_nib_nxt    = digits[{r_idx, 2'b00} +: 4];
                        w_dp_req_nxt = dp[r_idx];
                        w_dig_en_nxt = digit_en[r_idx];
                    end
                end
                S_ON: begin
                    if (r_cnt == L_SLOT_LAST) begin
                        w_state_nxt = S_GUARD;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + 2'd1;
                        w_wrap      = (r_idx == 2'd3);
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output logic: blank unless the next state lights a digit. A masked
    // digit still decodes SEG/DP but keeps its anode off, so every slot has
    // the same length and lit digits keep a uniform brightness.
    always_comb begin
        w_an_nxt  = 4'hF;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        w_fd_nxt  = w_wrap;
        if (w_state_nxt == S_ON) begin
            w_seg_nxt = f_decode(w_nib_nxt);
            w_dp_nxt  = ~w_dp_req_nxt;
            if (w_dig_en_nxt) begin
                w_an_nxt = ~(4'b0001 << w_idx_nxt);
            end
        end
    end

endmodule

// File: tb/tb_iob_sseg_scan.sv
// ---------------------------------------------------------------------------
// tb_iob_sseg_scan
// Bench for iob_sseg_scan with REFRESH_DIV=8, GUARD=2. The stimulus process
// queues the hand-computed display state expected at each sample time and
// drives the inputs; a monitor samples the outputs 1 time unit after every
// clock edge and every falling reset edge, and compares them with the queue.
// Sample time for the outputs after clock edge k is 10*k-4.
// ---------------------------------------------------------------------------
module tb_iob_sseg_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_done;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        longint     t;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        string      name;
    } exp_t;

    exp_t q[$];

    iob_sseg_scan #(
        .REFRESH_DIV(8),
        .GUARD      (2),
        .DIV_W      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .dp        (dp),
        .digit_en  (digit_en),
        .AN        (AN),
        .SEG       (SEG),
        .DP        (DP),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic ok, input string msg);
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL %s", msg);
        end
    endtask

    function automatic longint ts(input int k);
        return longint'(10 * k - 4);
    endfunction

    task automatic push(input longint t, input logic [3:0] an, input logic [6:0] seg,
                        input logic dpv, input logic fd, input string name);
        exp_t e;
        e.t = t; e.an = an; e.seg = seg; e.dp = dpv; e.fd = fd; e.name = name;
        q.push_back(e);
    endtask

    task automatic push_blank(input int k, input logic fd, input string name);
        push(ts(k), 4'hF, 7'h7F, 1'b1, fd, name);
    endtask

    // One slot starting at edge k0: two guard samples, then nlit lit samples.
    task automatic push_slot(input int k0, input logic [3:0] an, input logic [6:0] seg,
                             input logic dpv, input logic fd0, input int nlit,
                             input string name);
        push_blank(k0, fd0, {name, "_guard"});
        push_blank(k0 + 1, 1'b0, {name, "_guard"});
        for (int i = 0; i < nlit; i++) push(ts(k0 + 2 + i), an, seg, dpv, 1'b0, name);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Invariant: at most one anode is driven low in any cycle.
    always @(negedge clk) begin
        if (rst === 1'b1)
            check($countones(~AN) <= 1,
                  $sformatf("one_anode t=%0d: AN=%h has more than one bit low", $time, AN));
    end

    // Monitor: pops every expectation whose time has come and compares.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            while (q.size() > 0 && q[0].t < $time) begin
                e = q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL %s: sample at t=%0d never taken (now t=%0d)", e.name, e.t, $time);
            end
            while (q.size() > 0 && q[0].t == $time) begin
                e = q.pop_front();
                check({AN, SEG, DP, frame_done} === {e.an, e.seg, e.dp, e.fd},
                      $sformatf("%s t=%0d: got AN=%h SEG=%h DP=%b fd=%b, expected AN=%h SEG=%h DP=%b fd=%b",
                                e.name, $time, AN, SEG, DP, frame_done, e.an, e.seg, e.dp, e.fd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] an_t [4];
        logic [6:0] seg_t[4];
        logic       dp_t [4];
        an_t  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_t = '{7'h0E, 7'h08, 7'h24, 7'h79};
        dp_t  = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; en = 1'b1; digits = 16'h12AF; dp = 4'b0100; digit_en = 4'hF;

        // Reset held low with en=1: blank immediately and every cycle.
        push(3, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_async");
        for (int k = 1; k <= 4; k++) push_blank(k, 1'b0, "reset_hold");

        // Release at negedge after edge 4 -> E0 = edge 5. Two full frames.
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                push_slot(5 + 32 * f + 8 * s, an_t[s], seg_t[s], dp_t[s],
                          (f > 0 && s == 0), 6, "scan");

        // Frame 3: digits cleared during the 3rd ON cycle of digit 0.
        push_slot(69, 4'hE, 7'h0E, 1'b1, 1'b1, 6, "midslot_hold");
        push_slot(77, 4'hD, 7'h40, 1'b1, 1'b0, 6, "midslot_next");
        push_slot(85, 4'hB, 7'h40, 1'b0, 1'b0, 6, "midslot_d2");
        push_slot(93, 4'h7, 7'h40, 1'b1, 1'b0, 6, "midslot_d3");

        // Frame 4: digit_en = 1010, digits back to 12AF.
        push_slot(101, 4'hF, 7'h0E, 1'b1, 1'b1, 6, "mask_d0");
        push_slot(109, 4'hD, 7'h08, 1'b1, 1'b0, 6, "mask_d1");
        push_slot(117, 4'hF, 7'h24, 1'b0, 1'b0, 6, "mask_d2");
        push_slot(125, 4'h7, 7'h79, 1'b1, 1'b0, 6, "mask_d3");

        // Frame 5: en dropped after the 3rd ON cycle of digit 2.
        push_slot(133, 4'hE, 7'h0E, 1'b1, 1'b1, 6, "endrop_d0");
        push_slot(141, 4'hD, 7'h08, 1'b1, 1'b0, 6, "endrop_d1");
        push_slot(149, 4'hB, 7'h24, 1'b0, 1'b0, 3, "endrop_d2");
        for (int k = 154; k <= 157; k++) push_blank(k, 1'b0, "en_low");

        // Restart at edge 158; async reset pulse during digit 3's ON phase.
        for (int s = 0; s < 3; s++)
            push_slot(158 + 8 * s, an_t[s], seg_t[s], dp_t[s], 1'b0, 6, "restart");
        push_slot(182, 4'h7, 7'h79, 1'b1, 1'b0, 3, "restart_d3");
        push(1863, 4'hF, 7'h7F, 1'b1, 1'b0, "rst_pulse_async");

        // Scan resumes from digit 0 at edge 187; no frame_done at old wrap.
        for (int s = 0; s < 4; s++)
            push_slot(187 + 8 * s, an_t[s], seg_t[s], dp_t[s], 1'b0, 6, "after_rst");
        push_slot(219, 4'hE, 7'h0E, 1'b1, 1'b1, 6, "after_rst_frame");

        #2 rst = 1'b0;
        wait_cyc(4);
        rst = 1'b1;
        wait_cyc(73);
        digits = 16'h0000;
        wait_cyc(98);
        digits   = 16'h12AF;
        digit_en = 4'b1010;
        wait_cyc(128);
        digit_en = 4'hF;
        wait_cyc(153);
        en = 1'b0;
        wait_cyc(157);
        en = 1'b1;
        wait_cyc(186);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        wait_cyc(230);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: sample at t=%0d still pending at end", e.name, e.t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
